insn_step_sequencer: RTL

// - Multi-cycle RV32I control sequencer. Generalises the instruction clock decoder with an internal step FSM.
// - Latches the fetched instruction and generates the one-hot step code.
// - Resolves all six branch conditions from the EQ/LS/LU flags, and handshakes with data memory.
// - Sits between the instruction register/fetch path and the datapath muxes, register file and data memory.

---
 rtl/insn_step_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/insn_step_sequencer.sv
// -----------------------------------------------------------------------------
// insn_step_sequencer
//
// Multi-cycle RV32I control sequencer. A step FSM walks each instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB. It latches the fetched
// instruction and drives a one-hot step code. It resolves the six branch
// conditions from the ALU compare flags and handshakes with data memory,
// including a bounded wait with abort.
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcodes and BRANCH funct3 010/011 enter a sticky TRAP
//               state (code bit 5, o_illegal = 1) that is left only by reset.
//   undefined : those instructions retire as a NOP (pc_we only), TRAP is
//               unreachable and o_illegal is tied low.
//
// Ports
//   i_clk, i_reset    clock; synchronous active-high reset
//   i_insn            instruction word from fetch
//   i_insn_valid      i_insn valid; only consumed in FETCH
//   i_eq/i_ls/i_lu    ALU compare flags: equal, signed less, unsigned less
//   i_mem_ready       data memory completed the current access
//   o_code            one-hot step: b0 FETCH b1 DECODE b2 EXEC b3 MEM b4 WB b5 TRAP
//   o_insn_ld         instruction register load enable
//   o_sub_sra         ALU subtract / arithmetic shift select
//   o_addr_sel        memory address from ALU (1) vs PC (0)
//   o_pc_alu_sel      PC target base rs1 (JALR) vs PC
//   o_pc_next_sel     next PC = computed target (1) vs PC+4 (0)
//   o_rd_we, o_pc_we  register file / PC write strobes
//   o_mem_re, o_mem_we data memory read / write requests
//   o_mem_err         one-cycle pulse on memory access timeout
//   o_illegal         illegal instruction flag
//   o_busy            sequencer is not in FETCH
// -----------------------------------------------------------------------------
module insn_step_sequencer #(
  parameter int STEP_W  = 10,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_insn,
  input  logic              i_insn_valid,
  input  logic              i_eq,
  input  logic              i_ls,
  input  logic              i_lu,
  input  logic              i_mem_ready,
  output logic [STEP_W-1:0] o_code,
  output logic              o_insn_ld,
  output logic              o_sub_sra,
  output logic              o_addr_sel,
  output logic              o_pc_alu_sel,
  output logic              o_pc_next_sel,
  output logic              o_rd_we,
  output logic              o_pc_we,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic              o_mem_err,
  output logic              o_illegal,
  output logic              o_busy
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_insn_q;
  logic [31:0]       w_insn_nxt;
  logic              r_taken_q;
  logic              w_taken_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [5:0]        w_code6;

  // Branch condition select by funct3; reserved encodings never take.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic ls, input logic lu);
    logic res;
    case (f3)
      3'b000:  res = eq;
      3'b001:  res = ~eq;
      3'b100:  res = ls;
      3'b101:  res = ~ls;
      3'b110:  res = lu;
      3'b111:  res = ~lu;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Instruction class decode of the latched word
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic w_is_op, w_is_opimm, w_is_load, w_is_store, w_is_branch;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_known, w_legal;
  logic w_unused_insn_bits;

  assign w_opc       = r_insn_q[6:0];
  assign w_f3        = r_insn_q[14:12];
  assign w_is_op     = (w_opc == OPC_OP);
  assign w_is_opimm  = (w_opc == OPC_OPIMM);
  assign w_is_load   = (w_opc == OPC_LOAD);
  assign w_is_store  = (w_opc == OPC_STORE);
  assign w_is_branch = (w_opc == OPC_BRANCH);
  assign w_is_jal    = (w_opc == OPC_JAL);
  assign w_is_jalr   = (w_opc == OPC_JALR);
  assign w_is_lui    = (w_opc == OPC_LUI);
  assign w_is_auipc  = (w_opc == OPC_AUIPC);
  assign w_known     = w_is_op | w_is_opimm | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
  // funct3 010/011 have no branch meaning in RV32I
  assign w_legal     = w_known & ~(w_is_branch & (w_f3[2:1] == 2'b01));
  // Register fields are consumed by the datapath, not by this sequencer
  assign w_unused_insn_bits = ^{r_insn_q[31], r_insn_q[29:15], r_insn_q[11:7]};

  // State, instruction, branch-result and wait-counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_insn_q  <= 32'd0;
      r_taken_q <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_insn_q  <= w_insn_nxt;
      r_taken_q <= w_taken_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_insn_nxt  = r_insn_q;
    w_taken_nxt = r_taken_q;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_FETCH: begin
        if (i_insn_valid) begin
          w_insn_nxt  = i_insn;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (w_legal) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_TRAP;
        end
`else
        w_state_nxt = S_EXEC;
`endif
      end
      S_EXEC: begin
        // Compare flags are only meaningful during this cycle
        w_taken_nxt = w_is_branch & branch_taken(w_f3, i_eq, i_ls, i_lu);
        if (w_is_load | w_is_store) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        // Counter at TIMEOUT means the request was already dropped; abort
        // without retiring so fetch replays the same instruction.
        if (r_cnt == TIMEOUT_C) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (i_mem_ready) begin
          w_state_nxt = S_WB;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_MEM;
          w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Output decode from state and latched instruction
  always_comb begin
    w_code6       = 6'b000001;
    o_insn_ld     = 1'b0;
    o_sub_sra     = 1'b0;
    o_addr_sel    = 1'b0;
    o_pc_alu_sel  = 1'b0;
    o_pc_next_sel = 1'b0;
    o_rd_we       = 1'b0;
    o_pc_we       = 1'b0;
    o_mem_re      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_err     = 1'b0;
    o_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_code6   = 6'b000001;
        // Combinational so the IR loads on the same edge the word is offered
        o_insn_ld = i_insn_valid & ~i_reset;
      end
      S_DECODE: begin
        w_code6 = 6'b000010;
      end
      S_EXEC: begin
        w_code6 = 6'b000100;
        if (w_is_op) begin
          o_sub_sra = r_insn_q[30];
        end else if (w_is_opimm && (w_f3 == 3'b101)) begin
          o_sub_sra = r_insn_q[30];
        end else begin
          o_sub_sra = w_is_branch;
        end
      end
      S_MEM: begin
        w_code6    = 6'b001000;
        o_addr_sel = 1'b1;
        if (r_cnt == TIMEOUT_C) begin
          o_mem_err = 1'b1;
        end else begin
          o_mem_re = w_is_load;
          o_mem_we = w_is_store;
        end
      end
      S_WB: begin
        w_code6       = 6'b010000;
        o_pc_we       = 1'b1;
        o_rd_we       = w_legal & ~w_is_store & ~w_is_branch;
        o_pc_next_sel = w_is_jal | w_is_jalr | (w_is_branch & r_taken_q);
        o_pc_alu_sel  = w_is_jalr;
      end
      S_TRAP: begin
        w_code6 = 6'b100000;
`ifdef ILLEGAL_TRAP_EN
        o_illegal = 1'b1;
`else
        o_illegal = 1'b0;
`endif
      end
      default: begin
        w_code6 = 6'b000001;
      end
    endcase
  end

  assign o_code = STEP_W'(w_code6);
  assign o_busy = (r_state != S_FETCH);

endmodule
